// File: rtl/audio_ring_buffer_pkg.sv
// Shared types and constants for the audio ring buffer and its SPRAM bank wrapper.
package audio_ring_buffer_pkg;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } grant_e;

  localparam int SPRAM_AW = 14;
  localparam int SPRAM_DW = 16;

  // One enable bit per 4-bit nibble of the 16-bit SPRAM word; nibbles above data_w stay off.
  function automatic logic [3:0] nibble_mask(input int data_w);
    logic [3:0] m;
    for (int k = 0; k < 4; k++) begin
      m[k] = (data_w > 4 * k);
    end
    return m;
  endfunction

endpackage

// File: rtl/spram_bank.sv
// One SB_SPRAM256KA-style bank: 16-bit nibble-masked word, registered read, chip-select gated.
// Behavioural model of the primitive; narrower samples are zero-extended into the 16-bit word.
module spram_bank
  import audio_ring_buffer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int BANK_AW = 14
) (
  input  logic               i_clk,
  input  logic               i_cs,
  input  logic               i_we,
  input  logic [BANK_AW-1:0] i_addr,
  input  logic [DATA_W-1:0]  i_wdata,
  output logic [DATA_W-1:0]  o_rdata
);

  localparam logic [3:0] W_MASK = nibble_mask(DATA_W);

  logic [SPRAM_DW-1:0] r_mem [2**BANK_AW];
  logic [SPRAM_DW-1:0] r_dout;
  logic [SPRAM_DW-1:0] w_din;

  assign w_din = SPRAM_DW'(i_wdata);

  always_ff @(posedge i_clk) begin
    if (i_cs && i_we) begin
      for (int n = 0; n < 4; n++) begin
        if (W_MASK[n]) begin
          r_mem[i_addr][4*n +: 4] <= w_din[4*n +: 4];
        end
      end
    end
    // Read data appears the cycle after the select, as on the hard macro.
    if (i_cs && !i_we) begin
      r_dout <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_dout[DATA_W-1:0];

endmodule

// File: rtl/audio_ring_buffer.sv
// Single-port-SRAM audio ring buffer: one access per cycle shared between writes and
// read prefetches into a 2-entry output FIFO; optional overwrite-oldest when full.
module audio_ring_buffer
  import audio_ring_buffer_pkg::*;
#(
  parameter int  DATA_W    = 16,
  parameter int  BANK_AW   = 14,
  parameter int  NUM_BANKS = 4,
  localparam int DEPTH     = NUM_BANKS * (2 ** BANK_AW),
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mode,
  input  logic              i_clear,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_rd_ready,
  output logic [AW:0]       o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
);

  localparam int          BSW     = (NUM_BANKS > 1) ? AW - BANK_AW : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_mem_cnt;   // words in memory not yet fetched
  logic              r_inflight;
  logic [BSW-1:0]    r_rd_bank;
  logic [1:0]        r_of_cnt;
  logic [DATA_W-1:0] r_of_data [2];
  logic              r_overflow;
  grant_e            r_last_grant;

  logic [AW:0]          w_count;
  logic                 w_full;
  logic                 w_fetch_needed;
  logic                 w_can_write;
  logic                 w_wr_ready;
  logic                 w_wr_acc;
  logic                 w_fetch;
  logic                 w_overwrite;
  logic                 w_rd_valid;
  logic                 w_pop;
  logic [AW-1:0]        w_addr;
  logic [BSW-1:0]       w_bank;
  logic [BANK_AW-1:0]   w_word;
  logic [NUM_BANKS-1:0] w_bank_cs;
  logic [DATA_W-1:0]    w_bank_rdata [NUM_BANKS];
  logic [DATA_W-1:0]    w_ret_data;

  assign w_count        = r_mem_cnt + (AW + 1)'(r_inflight) + (AW + 1)'(r_of_cnt);
  assign w_full         = (w_count == DEPTH_C);
  assign w_fetch_needed = (r_mem_cnt != '0) &&
                          (({2'b00, r_inflight} + {1'b0, r_of_cnt}) < 3'd2);
  assign w_can_write    = !w_full || i_mode;
  // Writes yield to a pending fetch after a write grant, so neither side starves.
  assign w_wr_ready     = !i_reset && w_can_write && !i_clear &&
                          !(w_fetch_needed && (r_last_grant == WRITE));
  assign w_wr_acc       = i_wr_valid && w_wr_ready;
  assign w_fetch        = !i_reset && !i_clear && w_fetch_needed && !w_wr_acc;
  assign w_overwrite    = w_wr_acc && w_full;
  assign w_rd_valid     = !i_reset && (r_of_cnt != 2'd0);
  assign w_pop          = w_rd_valid && i_rd_ready;

  // Stage p0: shared memory port, address split into bank and word
  assign w_addr = w_wr_acc ? r_wr_ptr : r_rd_ptr;
  assign w_bank = BSW'(w_addr >> BANK_AW);
  assign w_word = w_addr[BANK_AW-1:0];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign w_bank_cs[b] = (w_wr_acc || w_fetch) && (w_bank == BSW'(b));

    spram_bank #(
      .DATA_W  (DATA_W),
      .BANK_AW (BANK_AW)
    ) u_bank (
      .i_clk   (i_clk),
      .i_cs    (w_bank_cs[b]),
      .i_we    (w_wr_acc),
      .i_addr  (w_word),
      .i_wdata (i_wr_data),
      .o_rdata (w_bank_rdata[b])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
      r_of_cnt   <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      // An overwrite drops the oldest unfetched word by stepping past it.
      if (w_fetch || w_overwrite) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_acc && !w_full) begin
        r_mem_cnt <= r_mem_cnt + (AW + 1)'(1);
      end else if (w_fetch) begin
        r_mem_cnt <= r_mem_cnt - (AW + 1)'(1);
      end
      r_inflight <= w_fetch;
      if (w_overwrite) r_overflow <= 1'b1;
      r_of_cnt <= r_of_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_grant <= WRITE;
    end else if (w_wr_acc) begin
      r_last_grant <= WRITE;
    end else if (w_fetch) begin
      r_last_grant <= READ;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_fetch) r_rd_bank <= w_bank;
  end

  // Stage p1: fetch return lands in the output FIFO
  assign w_ret_data = w_bank_rdata[r_rd_bank];

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_of_data[0] <= '0;
      r_of_data[1] <= '0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: r_of_data[r_of_cnt[0]] <= w_ret_data;
        2'b01: r_of_data[0] <= r_of_data[1];
        2'b11: begin
          if (r_of_cnt == 2'd2) begin
            r_of_data[0] <= r_of_data[1];
            r_of_data[1] <= w_ret_data;
          end else begin
            r_of_data[0] <= w_ret_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_wr_ready = w_wr_ready;
  assign o_rd_valid = w_rd_valid;
  assign o_rd_data  = r_of_data[0];
  assign o_count    = w_count;
  assign o_full     = w_full;
  assign o_empty    = (w_count == '0);
  assign o_overflow = r_overflow;

endmodule
